// File: rtl/lsu_mem_responder.sv
// ---------------------------------------------------------------------------
// lsu_mem_responder
//
// Memory-side responder for the LSU load/store bus. Holds a word-wide data
// RAM and answers one request at a time after a fixed, programmable latency.
// Load data is returned right-justified with the upper bytes zero. Store data
// arrives right-justified and is moved onto the addressed byte lanes.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   lsu_araddr/arvalid/rstrb  load request (level, held until rvalid)
//   lsu_rdata/rvalid          load response (rvalid is a one-cycle pulse)
//   lsu_awaddr/awvalid        store address (level)
//   lsu_wdata/wstrb/wvalid    store data (level)
//   lsu_wready                store completion (one-cycle pulse)
//   resp_err                  fault flag, meaningful only with rvalid/wready
// ---------------------------------------------------------------------------
module lsu_mem_responder #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                MEM_DEPTH = 1024,
  parameter int                LAT       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic              lsu_arvalid,
  input  logic [7:0]        lsu_rstrb,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_rvalid,
  input  logic [ADDR_W-1:0] lsu_awaddr,
  input  logic              lsu_awvalid,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_wstrb,
  input  logic              lsu_wvalid,
  output logic              lsu_wready,
  output logic              resp_err
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_WAIT = 3'd1;
  localparam logic [2:0] S_WR_WAIT = 3'd2;
  localparam logic [2:0] S_RESP    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              is_wr_q, is_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        strb_q, strb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic [ADDR_W-1:0] off;
  logic [1:0]        sh;
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              misaligned;
  logic              fault;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] rd_mask;
  logic [DATA_W-1:0] rd_val;
  logic [3:0]        be;
  logic [DATA_W-1:0] wr_shift;

  // Address decode and lane alignment, all from the latched request. The
  // request registers are stable from acceptance until the bubble after the
  // response, so both the load result and the store commit can use them.
  always_comb begin
    off      = addr_q - BASE_ADDR;
    sh       = off[1:0];
    idx      = off[IDX_W+1:2];
    in_range = (addr_q >= BASE_ADDR) && ((off >> 2) < ADDR_W'(MEM_DEPTH));

    case (strb_q)
      8'h01:   misaligned = 1'b0;
      8'h03:   misaligned = sh[0];
      8'h0f:   misaligned = (sh != 2'b00);
      default: misaligned = 1'b1;
    endcase
    fault = misaligned || !in_range;

    case (strb_q)
      8'h01:   rd_mask = DATA_W'(32'h0000_00ff);
      8'h03:   rd_mask = DATA_W'(32'h0000_ffff);
      8'h0f:   rd_mask = DATA_W'(32'hffff_ffff);
      default: rd_mask = '0;
    endcase

    word     = mem[idx];
    rd_shift = word >> {sh, 3'b000};
    rd_val   = rd_shift & rd_mask;
    be       = strb_q[3:0] << sh;
    wr_shift = wdata_q << {sh, 3'b000};
  end

  // Request sequencing. A complete store takes priority over a load in IDLE;
  // a lone awvalid is never accepted. The wait state lasts LAT+1 cycles, and
  // the load result and fault flag are captured on its last cycle so they are
  // registered during RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (lsu_awvalid && lsu_wvalid) begin
          is_wr_d = 1'b1;
          addr_d  = lsu_awaddr;
          wdata_d = lsu_wdata;
          strb_d  = lsu_wstrb;
          cnt_d   = 4'd0;
          state_d = S_WR_WAIT;
        end else if (lsu_arvalid) begin
          is_wr_d = 1'b0;
          addr_d  = lsu_araddr;
          strb_d  = lsu_rstrb;
          cnt_d   = 4'd0;
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT, S_WR_WAIT: begin
        if (cnt_q == 4'(LAT)) begin
          err_d   = fault;
          state_d = S_RESP;
          if (!is_wr_q) begin
            rdata_d = fault ? '0 : rd_val;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= 8'h00;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Store commit happens at the end of RESP. A store abandoned by reset never
  // reaches this state, so it never touches the RAM. RAM is not reset.
  always_ff @(posedge clk) begin
    if (state_q == S_RESP && is_wr_q && !err_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[idx][8*b +: 8] <= wr_shift[8*b +: 8];
        end
      end
    end
  end

  assign lsu_rdata  = rdata_q;
  assign lsu_rvalid = (state_q == S_RESP) && !is_wr_q;
  assign lsu_wready = (state_q == S_RESP) && is_wr_q;
  assign resp_err   = (state_q == S_RESP) && err_q;

endmodule

// File: tb/tb_lsu_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_responder
//
// Three responders (LAT=1, 0, 3) share address/data/strobe wires but each has
// its own valid lines, so one bench can measure every latency. Directed table
// vectors, hand-written corner sequences and a randomised phase checked
// against a byte-addressed memory model.
// ---------------------------------------------------------------------------
module tb_lsu_mem_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr, awaddr, wdata;
  logic [7:0]  rstrb, wstrb;
  logic [2:0]  ar_v, aw_v, w_v;
  logic [2:0]  rvalid_v, wready_v, err_v;
  logic [2:0][31:0] rdata_v;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_b [4*DEPTH];

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  strb;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [$];

  // Clock generation
  always #5 clk = ~clk;

  lsu_mem_responder #(.BASE_ADDR(BASE), .MEM_DEPTH(DEPTH), .LAT(1)) dut0 (
    .clk(clk), .rst(rst),
    .lsu_araddr(araddr), .lsu_arvalid(ar_v[0]), .lsu_rstrb(rstrb),
    .lsu_rdata(rdata_v[0]), .lsu_rvalid(rvalid_v[0]),
    .lsu_awaddr(awaddr), .lsu_awvalid(aw_v[0]), .lsu_wdata(wdata),
    .lsu_wstrb(wstrb), .lsu_wvalid(w_v[0]), .lsu_wready(wready_v[0]),
    .resp_err(err_v[0]));

  lsu_mem_responder #(.BASE_ADDR(BASE), .MEM_DEPTH(DEPTH), .LAT(0)) dut1 (
    .clk(clk), .rst(rst),
    .lsu_araddr(araddr), .lsu_arvalid(ar_v[1]), .lsu_rstrb(rstrb),
    .lsu_rdata(rdata_v[1]), .lsu_rvalid(rvalid_v[1]),
    .lsu_awaddr(awaddr), .lsu_awvalid(aw_v[1]), .lsu_wdata(wdata),
    .lsu_wstrb(wstrb), .lsu_wvalid(w_v[1]), .lsu_wready(wready_v[1]),
    .resp_err(err_v[1]));

  lsu_mem_responder #(.BASE_ADDR(BASE), .MEM_DEPTH(DEPTH), .LAT(3)) dut2 (
    .clk(clk), .rst(rst),
    .lsu_araddr(araddr), .lsu_arvalid(ar_v[2]), .lsu_rstrb(rstrb),
    .lsu_rdata(rdata_v[2]), .lsu_rvalid(rvalid_v[2]),
    .lsu_awaddr(awaddr), .lsu_awvalid(aw_v[2]), .lsu_wdata(wdata),
    .lsu_wstrb(wstrb), .lsu_wvalid(w_v[2]), .lsu_wready(wready_v[2]),
    .resp_err(err_v[2]));

  function automatic int latOf(input int sel);
    return (sel == 0) ? 1 : (sel == 1) ? 0 : 3;
  endfunction

  // Reference model: byte-addressed memory, access size from the strobe,
  // natural alignment required, window [BASE, BASE + 4*DEPTH).
  function automatic void modelAccess(input bit is_wr, input logic [31:0] addr,
                                      input logic [31:0] wd, input logic [7:0] strb,
                                      output logic [31:0] rd, output bit err);
    int     n;
    longint off;
    n   = (strb == 8'h01) ? 1 : (strb == 8'h03) ? 2 : (strb == 8'h0f) ? 4 : 0;
    off = longint'(addr) - longint'(BASE);
    rd  = 32'h0;
    err = 1'b0;
    if (n == 0 || off < 0 || off >= 4 * DEPTH) err = 1'b1;
    else if ((off % n) != 0) err = 1'b1;
    if (!err) begin
      for (int i = 0; i < n; i++) begin
        if (is_wr) mem_b[int'(off) + i] = wd[8*i +: 8];
        else       rd[8*i +: 8] = mem_b[int'(off) + i];
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Issues one request on responder 'sel' (entered #1 after an edge with the
  // responder idle), waits up to 40 cycles for a pulse, then drops the valids
  // and lets the DONE bubble pass. got_lat = -1 on timeout.
  task automatic applyStimulus(input int sel, input bit is_wr, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [7:0] strb,
                               output logic [31:0] got_rdata, output logic got_err,
                               output int got_lat, output logic kind_ok);
    got_rdata = 32'h0;
    got_err   = 1'b0;
    got_lat   = -1;
    kind_ok   = 1'b0;
    if (is_wr) begin
      awaddr = addr; wdata = wd; wstrb = strb;
      aw_v[sel] = 1'b1; w_v[sel] = 1'b1;
    end else begin
      araddr = addr; rstrb = strb;
      ar_v[sel] = 1'b1;
    end
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (rvalid_v[sel] || wready_v[sel]) begin
        got_lat   = k;
        got_rdata = rdata_v[sel];
        got_err   = err_v[sel];
        kind_ok   = is_wr ? (wready_v[sel] && !rvalid_v[sel]) : (rvalid_v[sel] && !wready_v[sel]);
        break;
      end
    end
    ar_v[sel] = 1'b0; aw_v[sel] = 1'b0; w_v[sel] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  // Runs a request on responder 0 and checks it against the model.
  task automatic modelTxn(input string name, input bit is_wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [7:0] strb);
    logic [31:0] got_rd, exp_rd;
    logic        got_err, kind_ok;
    bit          exp_err;
    int          lat;
    modelAccess(is_wr, addr, wd, strb, exp_rd, exp_err);
    applyStimulus(0, is_wr, addr, wd, strb, got_rd, got_err, lat, kind_ok);
    checkOutput({name, "_lat"}, 32'(lat), 32'd3);
    checkOutput({name, "_kind"}, 32'(kind_ok), 32'd1);
    checkOutput({name, "_err"}, 32'(got_err), 32'(exp_err));
    if (!is_wr) checkOutput({name, "_rdata"}, got_rd, exp_rd);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] got_rd, exp_rd, rd_d;
    logic        got_err, kind_ok, first_r;
    bit          err_d;
    int          lat, k1, k2, pulses;

    // Directed vectors, applied in order on the LAT=1 responder.
    vecs.push_back('{1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0f, 0, 32'h0});
    vecs.push_back('{0, 32'h8000_0010, 32'h0,         8'h0f, 0, 32'hDEAD_BEEF});
    vecs.push_back('{1, 32'h8000_0011, 32'h0000_0055, 8'h01, 0, 32'h0});
    vecs.push_back('{0, 32'h8000_0010, 32'h0,         8'h0f, 0, 32'hDEAD_55EF});
    vecs.push_back('{0, 32'h8000_0013, 32'h0,         8'h01, 0, 32'h0000_00DE});
    vecs.push_back('{0, 32'h8000_0012, 32'h0,         8'h03, 0, 32'h0000_DEAD});
    vecs.push_back('{0, 32'h8000_0002, 32'h0,         8'h0f, 1, 32'h0});
    vecs.push_back('{1, 32'h8000_0011, 32'h0000_BEEF, 8'h03, 1, 32'h0});
    vecs.push_back('{0, 32'h8000_0010, 32'h0,         8'h0f, 0, 32'hDEAD_55EF});
    vecs.push_back('{0, 32'h7FFF_FFFC, 32'h0,         8'h0f, 1, 32'h0});
    vecs.push_back('{0, 32'h8000_1000, 32'h0,         8'h0f, 1, 32'h0});
    vecs.push_back('{1, 32'h8000_0FFC, 32'hA5A5_0001, 8'h0f, 0, 32'h0});
    vecs.push_back('{0, 32'h8000_0FFC, 32'h0,         8'h0f, 0, 32'hA5A5_0001});
    vecs.push_back('{0, 32'h8000_0FFE, 32'h0,         8'h01, 0, 32'h0000_00A5});
    vecs.push_back('{0, 32'h8000_0FFC, 32'h0,         8'h03, 0, 32'h0000_0001});
    vecs.push_back('{0, 32'h8000_0010, 32'h0,         8'h07, 1, 32'h0});
    vecs.push_back('{1, 32'h8000_0013, 32'hFFFF_FF77, 8'h01, 0, 32'h0});
    vecs.push_back('{0, 32'h8000_0010, 32'h0,         8'h0f, 0, 32'h77AD_55EF});
    vecs.push_back('{0, 32'h8000_0013, 32'h0,         8'h03, 1, 32'h0});
    vecs.push_back('{1, 32'h7FFF_FFFC, 32'h1111_1111, 8'h0f, 1, 32'h0});
    vecs.push_back('{1, 32'h8000_0020, 32'hCAFE_F00D, 8'h0f, 0, 32'h0});
    vecs.push_back('{0, 32'h8000_0020, 32'h0,         8'h0f, 0, 32'hCAFE_F00D});

    rst = 1'b1;
    ar_v = '0; aw_v = '0; w_v = '0;
    araddr = '0; awaddr = '0; wdata = '0; rstrb = '0; wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_rvalid", 32'(rvalid_v), 32'd0);
    checkOutput("reset_wready", 32'(wready_v), 32'd0);
    checkOutput("reset_err", 32'(err_v), 32'd0);
    checkOutput("reset_rdata", rdata_v[0], 32'h0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      modelAccess(vecs[i].is_wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd_d, err_d);
      applyStimulus(0, vecs[i].is_wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                    got_rd, got_err, lat, kind_ok);
      checkOutput($sformatf("vec%0d_lat", i), 32'(lat), 32'd3);
      checkOutput($sformatf("vec%0d_kind", i), 32'(kind_ok), 32'd1);
      checkOutput($sformatf("vec%0d_err", i), 32'(got_err), 32'(vecs[i].exp_err));
      if (!vecs[i].is_wr)
        checkOutput($sformatf("vec%0d_rdata", i), got_rd, vecs[i].exp_rdata);
    end

    // Load and complete store together: store first, load after the bubble.
    araddr = BASE + 32'h10; rstrb = 8'h0f;
    awaddr = BASE + 32'h14; wdata = 32'h1122_3344; wstrb = 8'h0f;
    ar_v[0] = 1'b1; aw_v[0] = 1'b1; w_v[0] = 1'b1;
    k1 = -1; k2 = -1; first_r = 1'b1; got_rd = '0; got_err = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k1 < 0 && wready_v[0]) begin
        k1 = k; first_r = rvalid_v[0];
        aw_v[0] = 1'b0; w_v[0] = 1'b0;
      end else if (rvalid_v[0]) begin
        k2 = k; got_rd = rdata_v[0]; got_err = err_v[0];
        break;
      end
    end
    ar_v[0] = 1'b0; aw_v[0] = 1'b0; w_v[0] = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    modelAccess(1'b1, BASE + 32'h14, 32'h1122_3344, 8'h0f, rd_d, err_d);
    modelAccess(1'b0, BASE + 32'h10, 32'h0, 8'h0f, exp_rd, err_d);
    checkOutput("both_store_lat", 32'(k1), 32'd3);
    checkOutput("both_no_early_load", 32'(first_r), 32'd0);
    checkOutput("both_load_gap", 32'(k2 - k1), 32'd5);
    checkOutput("both_load_rdata", got_rd, exp_rd);
    checkOutput("both_load_err", 32'(got_err), 32'd0);
    modelTxn("both_readback", 1'b0, BASE + 32'h14, 32'h0, 8'h0f);

    // Store address without data is never accepted.
    awaddr = BASE + 32'h18; wdata = 32'h9999_9999; wstrb = 8'h0f;
    aw_v[0] = 1'b1; pulses = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (wready_v[0] || rvalid_v[0]) pulses++;
    end
    checkOutput("aw_only_pulses", 32'(pulses), 32'd0);
    // A load is still accepted while the lone awvalid is held.
    modelTxn("aw_only_load", 1'b0, BASE + 32'h10, 32'h0, 8'h0f);

    // Reset in WR_WAIT abandons the store.
    awaddr = BASE + 32'h20; wdata = 32'h1234_5678; wstrb = 8'h0f;
    aw_v[0] = 1'b1; w_v[0] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; aw_v[0] = 1'b0; w_v[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; pulses = 0;
    for (int k = 0; k < 6; k++) begin
      if (wready_v[0] || rvalid_v[0]) pulses++;
      @(posedge clk); #1;
    end
    checkOutput("rst_no_pulse", 32'(pulses), 32'd0);
    applyStimulus(0, 1'b0, BASE + 32'h20, 32'h0, 8'h0f, got_rd, got_err, lat, kind_ok);
    checkOutput("rst_old_value", got_rd, 32'hCAFE_F00D);
    checkOutput("rst_old_err", 32'(got_err), 32'd0);

    // Latency of LAT=0 and LAT=3 responders.
    for (int s = 1; s <= 2; s++) begin
      applyStimulus(s, 1'b1, BASE + 32'h40, 32'h0BAD_F00D, 8'h0f, got_rd, got_err, lat, kind_ok);
      checkOutput($sformatf("lat%0d_store_lat", latOf(s)), 32'(lat), 32'(latOf(s) + 2));
      checkOutput($sformatf("lat%0d_store_kind", latOf(s)), 32'(kind_ok), 32'd1);
      applyStimulus(s, 1'b0, BASE + 32'h40, 32'h0, 8'h0f, got_rd, got_err, lat, kind_ok);
      checkOutput($sformatf("lat%0d_load_lat", latOf(s)), 32'(lat), 32'(latOf(s) + 2));
      checkOutput($sformatf("lat%0d_load_rdata", latOf(s)), got_rd, 32'h0BAD_F00D);
    end

    // Randomised phase on a 16-word window, seeded with known words first.
    for (int w = 0; w < 16; w++)
      modelTxn($sformatf("init%0d", w), 1'b1, BASE + 32'(4 * w), $urandom, 8'h0f);
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      logic [7:0]  s;
      int          r;
      r = $urandom_range(0, 7);
      s = (r < 3) ? 8'h01 : (r < 5) ? 8'h03 : (r < 7) ? 8'h0f : 8'($urandom_range(0, 255));
      r = $urandom_range(0, 9);
      if (r == 0)      a = BASE - 32'd64 + 32'($urandom_range(0, 63));
      else if (r == 1) a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 63));
      else             a = BASE + 32'($urandom_range(0, 63));
      modelTxn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), a, $urandom, s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_responder.md
Name: lsu_mem_responder

Overview:
- Memory-side responder for the LSU load/store bus; it terminates the read channel (araddr/arvalid/rstrb -> rdata/rvalid) and the write channel (awaddr/awvalid/wdata/wstrb/wvalid -> wready).
- Backed by an internal word-wide data RAM with a programmable response latency.
- Performs byte-lane alignment so the LSU sees load data right-justified and supplies store data right-justified.
- Used as the data memory in core-level simulation and as a stand-in for the SoC data port.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (fixed 32; one word per entry)
- BASE_ADDR, 32'h8000_0000, byte address of entry 0
- MEM_DEPTH, 1024, number of 32-bit words
- LAT, 1, extra wait cycles before response (0..15)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- lsu_araddr  in  ADDR_W  load byte address
- lsu_arvalid  in  1  load request, level, held by master until rvalid
- lsu_rstrb  in  8  load size: 8'h1 byte, 8'h3 half, 8'hf word
- lsu_rdata  out  DATA_W  load data, right-justified, upper bytes zero
- lsu_rvalid  out  1  one-cycle load response pulse
- lsu_awaddr  in  ADDR_W  store byte address
- lsu_awvalid  in  1  store address valid, level
- lsu_wdata  in  DATA_W  store data, right-justified
- lsu_wstrb  in  8  store size: 8'h1/8'h3/8'hf
- lsu_wvalid  in  1  store data valid, level
- lsu_wready  out  1  one-cycle store completion pulse
- resp_err  out  1  valid only with rvalid/wready; 1 = access faulted

Behaviour:
- Clock/reset: one clock (clk); rst synchronous, active-high.
- Reset values: lsu_rvalid=0, lsu_wready=0, resp_err=0, lsu_rdata=0, FSM=IDLE, latency counter=0. RAM contents are not reset.
- FSM states: IDLE, RD_WAIT, WR_WAIT, RESP, DONE.
- IDLE transitions:
  - awvalid&wvalid -> latch awaddr/wdata/wstrb, go WR_WAIT.
  - else arvalid -> latch araddr/rstrb, go RD_WAIT.
  - awvalid without wvalid: not accepted; stay IDLE; a pending arvalid in that cycle is still accepted.
  - Simultaneous load and complete store in IDLE: store wins; load is accepted later from DONE->IDLE if still held.
- RD_WAIT/WR_WAIT: count LAT cycles, then go RESP. With LAT=0 the state lasts one cycle.
- Latency: a request accepted in IDLE at cycle T gets its response pulse at cycle T+2+LAT.
- RESP cycle:
  - Read: rvalid=1 and rdata valid.
  - Write: RAM write commits at this edge, and wready=1.
  - resp_err is valid in this cycle.
  - Next state is DONE.
- DONE: one bubble cycle with all outputs deasserted and inputs ignored, then IDLE. The master must drop arvalid/awvalid in DONE or it issues a new request.
- Decode:
  - off = addr - BASE_ADDR; idx = off[ADDR_W-1:2]; sh = off[1:0].
  - In range iff addr >= BASE_ADDR and idx < MEM_DEPTH.
- Alignment faults:
  - strb 8'h3 with sh[0]=1, or strb 8'hf with sh!=0.
  - Any strb value other than 8'h1/8'h3/8'hf.
- Read:
  - rdata = (RAM[idx] >> 8*sh) masked to the strb width; bytes above the size are 0 (sign extension is done by the LSU).
  - On fault or out of range: rdata=0, resp_err=1.
- Write:
  - Byte-enable = strb << sh; data = wdata << 8*sh; only enabled bytes of RAM[idx] change.
  - On fault or out of range: no RAM change, resp_err=1, wready still pulses.
- Read-after-write: a load accepted after a store's RESP returns the new data; there is no forwarding hazard because only one request is outstanding.
- Reset mid-transaction: abandons it. A store not yet in RESP never reaches RAM. No rvalid/wready pulse follows the reset.
- lsu_rdata holds its last value outside RESP (don't-care); benches sample only when rvalid=1.

Test Plan:
- LAT=1, rst then sw 0x8000_0010 wdata=0xDEADBEEF wstrb=f (accept T) -> wready=1, resp_err=0 at T+3; lw same addr -> rvalid at T'+3, rdata=0xDEADBEEF.
- sb 0x8000_0011 wdata=0x55 on word 0xDEADBEEF -> word becomes 0xDEAD55EF; lbu 0x8000_0013 -> rdata=0x000000DE; lhu 0x8000_0012 -> 0x0000DEAD.
- Misaligned lw 0x8000_0002 -> rvalid with resp_err=1, rdata=0; sh 0x8000_0011 -> wready with resp_err=1, RAM unchanged.
- Out of range: lw 0x7FFF_FFFC and lw BASE+4*MEM_DEPTH -> resp_err=1, rdata=0.
- arvalid and awvalid/wvalid asserted together in IDLE -> store answered first (wready), load answered after DONE; awvalid held with wvalid=0 for 5 cycles -> no wready.
- rst asserted in WR_WAIT of a sw 0x8000_0020 0x12345678 -> no wready pulse, following lw returns the old value; LAT=0 and LAT=3 latency measured as 2 and 5 cycles.
